// File: rtl/wb_write_arbiter.sv
// Writeback arbiter for the register file's single write port.
// Merges single-cycle pipeline results with long-latency results held in a
// small FIFO, issues one registered write per cycle, and publishes a mask of
// destinations still waiting in the FIFO for the hazard logic.
module wb_write_arbiter #(
  parameter int XLEN         = 32,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          pipe_we,
  input  logic [4:0]                    pipe_rd,
  input  logic [XLEN-1:0]               pipe_data,
  output logic                          pipe_stall,
  input  logic                          lu_valid,
  output logic                          lu_ready,
  input  logic [4:0]                    lu_rd,
  input  logic [XLEN-1:0]               lu_data,
  output logic                          rf_we,
  output logic [4:0]                    rf_rd,
  output logic [XLEN-1:0]               rf_wdata,
  output logic [31:0]                   pend_mask,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);

  logic [4:0]            rd_q   [FIFO_DEPTH];
  logic [XLEN-1:0]       data_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] occ_q;
  logic [AW-1:0]         head_q;
  logic [AW-1:0]         tail_q;
  logic [CW-1:0]         count_q;
  logic [SW-1:0]         starve_q;

  logic fifo_nonempty;
  logic stall_win;
  logic pipe_valid;
  logic pipe_win;
  logic pop;
  logic push;

  // Arbitration decision for this cycle, all from registered FIFO state
  always_comb begin
    fifo_nonempty = (count_q != '0);
    stall_win     = fifo_nonempty && (starve_q >= STARVE_MAX);
    pipe_valid    = pipe_we && (pipe_rd != 5'd0);
    pipe_win      = !stall_win && pipe_valid;
    pop           = stall_win || (!pipe_valid && fifo_nonempty);
    lu_ready      = (count_q < DEPTH_C);
    push          = lu_valid && lu_ready && (lu_rd != 5'd0);
  end

  assign pipe_stall = stall_win;
  assign fifo_count = count_q;

  // FIFO storage, pointers and occupancy; x0 results are accepted but dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
      occ_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        rd_q[tail_q]   <= lu_rd;
        data_q[tail_q] <= lu_data;
        occ_q[tail_q]  <= 1'b1;
        tail_q         <= tail_q + 1'b1;
      end
      if (pop) begin
        occ_q[head_q] <= 1'b0;
        head_q        <= head_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Starvation counter: counts cycles a waiting head loses to the pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else if (pop || !fifo_nonempty) begin
      starve_q <= '0;
    end else if (starve_q < STARVE_MAX) begin
      starve_q <= starve_q + 1'b1;
    end
  end

  // Registered write port: the winner of this cycle is written next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
    end else if (pop) begin
      rf_we    <= 1'b1;
      rf_rd    <= rd_q[head_q];
      rf_wdata <= data_q[head_q];
    end else if (pipe_win) begin
      rf_we    <= 1'b1;
      rf_rd    <= pipe_rd;
      rf_wdata <= pipe_data;
    end else begin
      rf_we    <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
    end
  end

  // Pending-destination mask over every occupied FIFO slot
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (occ_q[i]) begin
        pend_mask = pend_mask | (32'd1 << rd_q[i]);
      end
    end
  end

endmodule
